serial_twos_decoder: RTL and testbench

Serial-to-parallel decoder for LSB-first two's-complement bit streams. Accepts one bit per handshake, optionally re-negates the stream on the fly (copy bits up to and including the first 1, invert the rest), and assembles WIDTH bits into a parallel word. The word is presented on a valid/ready output. It sits at the receive end of the serial two's-complement path and recovers the original operand from a complemented stream, or passes a plain stream through.

---
 rtl/serial_pkg.sv | 8 +
 rtl/serial_twos_decoder_if.sv | 21 ++
 rtl/serial_negate_cell.sv | 22 ++
 rtl/serial_twos_decoder.sv | 79 +++++++
 tb/tb_serial_twos_decoder.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared types and sizing helpers for the serial two's-complement path
package serial_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    localparam int DEF_WIDTH = 8;
    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/serial_twos_decoder_if.sv
// serial_twos_decoder_if: serial bit input and parallel word output handshakes
interface serial_twos_decoder_if #(parameter int WIDTH = serial_pkg::DEF_WIDTH);
    logic             bit_in;
    logic             bit_valid;
    logic             frame_start;
    logic             negate;
    logic             in_ready;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic             ovf;
    logic             frame_err;
    modport master (
        output bit_in, bit_valid, frame_start, negate, word_ready,
        input  in_ready, word_out, word_valid, ovf, frame_err
    );
    modport slave (
        input  bit_in, bit_valid, frame_start, negate, word_ready,
        output in_ready, word_out, word_valid, ovf, frame_err
    );
endinterface

// File: rtl/serial_negate_cell.sv
// serial_negate_cell: on-the-fly two's-complement negation of an LSB-first bit stream
module serial_negate_cell (
    input  logic clk,
    input  logic n_reset,
    input  logic clear,
    input  logic advance,
    input  logic negate,
    input  logic bit_in,
    output logic d
);
    logic seen_one;
    // clear applies to the bit being decoded, so a frame's LSB always passes straight through
    assign d = negate & seen_one & ~clear ? ~bit_in : bit_in;
    always_ff @(posedge clk) begin
        if (n_reset)
            seen_one <= 1'b0;
        else if (advance)
            seen_one <= (seen_one & ~clear) | bit_in;
        else if (clear)
            seen_one <= 1'b0;
    end
endmodule

// File: rtl/serial_twos_decoder.sv
// serial_twos_decoder: LSB-first serial stream to parallel word with optional re-negation
module serial_twos_decoder #(
    parameter int WIDTH = serial_pkg::DEF_WIDTH
) (
    input logic clk,
    input logic n_reset,
    serial_twos_decoder_if.slave bus
);
    import serial_pkg::*;
    localparam int CW = count_width(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    state_t state, state_n;
    logic [CW-1:0] count, count_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic negate_l, negate_n, ovf_r, ovf_n, ferr, ferr_n;
    logic accept, clear, advance, d;
    assign bus.in_ready = state != HOLD;
    assign accept = bus.bit_valid & bus.in_ready;
    serial_negate_cell u_cell (
        .clk(clk),
        .n_reset(n_reset),
        .clear(clear),
        .advance(advance),
        .negate(negate_l),
        .bit_in(bus.bit_in),
        .d(d)
    );
    always_comb begin
        state_n = state;
        count_n = count;
        sreg_n = sreg;
        negate_n = negate_l;
        ferr_n = 1'b0;
        clear = 1'b0;
        advance = 1'b0;
        if (accept) begin
            if (bus.frame_start) begin
                ferr_n = state == SHIFT;
                clear = 1'b1;
                advance = 1'b1;
                negate_n = bus.negate;
                count_n = CW'(1);
                sreg_n = {d, sreg[WIDTH-1:1]};
                state_n = SHIFT;
            end else if (state == SHIFT) begin
                advance = 1'b1;
                count_n = count + CW'(1);
                sreg_n = {d, sreg[WIDTH-1:1]};
                state_n = count == CW'(WIDTH - 1) ? HOLD : SHIFT;
            end else begin
                ferr_n = 1'b1;
            end
        end else if (state == HOLD && bus.word_ready) begin
            state_n = IDLE;
        end
        ovf_n = state_n == HOLD && negate_l && sreg_n == MIN_VAL;
    end
    always_ff @(posedge clk) begin
        if (n_reset) begin
            state <= IDLE;
            count <= '0;
            sreg <= '0;
            negate_l <= 1'b0;
            ovf_r <= 1'b0;
            ferr <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            sreg <= sreg_n;
            negate_l <= negate_n;
            ovf_r <= ovf_n;
            ferr <= ferr_n;
        end
    end
    assign bus.word_out = sreg;
    assign bus.word_valid = state == HOLD;
    assign bus.ovf = ovf_r;
    assign bus.frame_err = ferr;
endmodule

// File: tb/tb_serial_twos_decoder.sv
// tb_serial_twos_decoder: table-driven and scoreboard checks of the serial two's-complement decoder
module tb_serial_twos_decoder;
    logic clk = 1'b0;
    logic n_reset = 1'b1;
    always #5 clk = ~clk;

    serial_twos_decoder_if #(.WIDTH(8)) bus ();
    serial_twos_decoder #(.WIDTH(8)) dut (.clk(clk), .n_reset(n_reset), .bus(bus));

    typedef struct { logic [7:0] word; logic ovf; } exp_t;
    typedef struct { logic [7:0] val; logic neg; logic [7:0] word; logic ovf; } vec_t;
    exp_t sb[$];
    exp_t e;
    vec_t vecs[8];
    int total = 0, bad = 0, words = 0, ferrs = 0;
    int f0, w0;
    logic ferr_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!n_reset) begin
            if (bus.word_valid) chk("in_ready_in_hold", bus.in_ready, 0);
            if (bus.word_valid && bus.word_ready) begin
                words++;
                if (sb.size() == 0) chk("scoreboard_nonempty", sb.size(), 1);
                else begin
                    e = sb.pop_front();
                    chk("word_out", bus.word_out, e.word);
                    chk("ovf", bus.ovf, e.ovf);
                end
            end
            if (bus.frame_err) begin
                ferrs++;
                chk("frame_err_one_cycle", ferr_prev, 0);
            end
            ferr_prev = bus.frame_err;
        end
    end

    task automatic send_bit(input logic b, input logic fs, input logic ng);
        int t;
        t = 0;
        @(negedge clk);
        bus.bit_in = b;
        bus.bit_valid = 1'b1;
        bus.frame_start = fs;
        bus.negate = ng;
        while (!bus.in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) chk("in_ready_timeout", t, 0);
        @(posedge clk);
        #1;
        bus.bit_valid = 1'b0;
        bus.frame_start = 1'b0;
        bus.negate = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] val, input logic neg, input logic [7:0] w,
                             input logic o, input int gap);
        sb.push_back('{word: w, ovf: o});
        for (int i = 0; i < 8; i++) begin
            if (i == 2 || i == 5) repeat (gap) @(negedge clk);
            send_bit(val[i], i == 0, neg);
            chk(i == 7 ? "valid_after_last" : "valid_mid_word", bus.word_valid, i == 7);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{8'hFB, 1'b1, 8'h05, 1'b0};
        vecs[1] = '{8'hA5, 1'b0, 8'hA5, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 8'h80, 1'b1};
        vecs[4] = '{8'h01, 1'b1, 8'hFF, 1'b0};
        vecs[5] = '{8'h7F, 1'b1, 8'h81, 1'b0};
        vecs[6] = '{8'h80, 1'b0, 8'h80, 1'b0};
        vecs[7] = '{8'h0C, 1'b1, 8'hF4, 1'b0};
        bus.bit_in = 1'b0;
        bus.bit_valid = 1'b0;
        bus.frame_start = 1'b0;
        bus.negate = 1'b0;
        bus.word_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b0;
        @(negedge clk);
        chk("rst_word_out", bus.word_out, 0);
        chk("rst_word_valid", bus.word_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_frame_err", bus.frame_err, 0);

        foreach (vecs[i]) send_word(vecs[i].val, vecs[i].neg, vecs[i].word, vecs[i].ovf, 0);
        drain();

        // backpressure: gaps mid-word, then downstream stalls while the next LSB is offered
        bus.word_ready = 1'b0;
        send_word(8'h3C, 1'b0, 8'h3C, 1'b0, 2);
        fork
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("hold_in_ready", bus.in_ready, 0);
                    chk("hold_word_valid", bus.word_valid, 1);
                    chk("hold_word_out", bus.word_out, 8'h3C);
                end
                @(posedge clk);
                #1 bus.word_ready = 1'b1;
            end
            send_word(8'h39, 1'b1, 8'hC7, 1'b0, 0);
        join
        drain();

        f0 = ferrs;
        for (int i = 0; i < 4; i++) send_bit(i[0], i == 0, 1'b1);
        send_word(8'hFB, 1'b1, 8'h05, 1'b0, 0);
        drain();
        chk("frame_err_restart", ferrs - f0, 1);

        f0 = ferrs;
        w0 = words;
        send_bit(1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("frame_err_idle", ferrs - f0, 1);
        chk("idle_no_word", words - w0, 0);
        chk("idle_word_valid", bus.word_valid, 0);

        f0 = ferrs;
        for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0, 1'b1);
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        chk("midrst_word_out", bus.word_out, 0);
        chk("midrst_word_valid", bus.word_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_ovf", bus.ovf, 0);
        chk("midrst_frame_err", bus.frame_err, 0);
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_no_frame_err", ferrs - f0, 0);
        send_word(8'hFB, 1'b1, 8'h05, 1'b0, 0);
        drain();
        chk("word_count", words, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
